// File: rtl/cpu_wb_mul_pkg.sv
// Shared constants for the Wishbone iterative shift-add multiplier:
// register word addresses, CTRL bit positions and FSM state encoding.
package cpu_wb_mul_pkg;

    localparam logic [2:0] ADR_OPA    = 3'd0;
    localparam logic [2:0] ADR_OPB    = 3'd1;
    localparam logic [2:0] ADR_CTRL   = 3'd2;
    localparam logic [2:0] ADR_RES_LO = 3'd3;
    localparam logic [2:0] ADR_RES_HI = 3'd4;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_DONE_CLR = 1;
    localparam int CTRL_IRQ_ENA  = 2;
    // CTRL read bits
    localparam int CTRL_BUSY     = 0;
    localparam int CTRL_DONE     = 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cpu_wb_cla_adder.sv
// Combinational generate/propagate adder shared by the CPU bus arithmetic
// blocks; carry chain is the lookahead recurrence c[i+1] = g[i] | p[i]&c[i].
module cpu_wb_cla_adder #(
    parameter int DATA_WID = 32
) (
    input  logic [DATA_WID-1:0] a,
    input  logic [DATA_WID-1:0] b,
    input  logic                carry_in,
    output logic [DATA_WID-1:0] sum,
    output logic                carry_out
);

    logic [DATA_WID-1:0] gen;
    logic [DATA_WID-1:0] prop;
    logic [DATA_WID:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        carry[0] = carry_in;
        for (int i = 0; i < DATA_WID; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum       = prop ^ carry[DATA_WID-1:0];
    assign carry_out = carry[DATA_WID];

endmodule

// File: rtl/cpu_wb_mul_ctrl.sv
// Wishbone B4 classic slave running a one-bit-per-clock shift-add multiplier.
// Define CPU_WB_MUL_IRQ_EN to add the irq_o port and the CTRL IRQ_ENA bit.
module cpu_wb_mul_ctrl
    import cpu_wb_mul_pkg::*;
#(
    parameter  int DATA_WID = 32,
    localparam int CNT_WID  = $clog2(DATA_WID) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o
`ifdef CPU_WB_MUL_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    logic                state;
    logic [CNT_WID-1:0]  cnt;
    logic [DATA_WID-1:0] opa, opb;
    logic [DATA_WID-1:0] mcand, mplier, acc;
    logic [DATA_WID-1:0] res_lo, res_hi;
    logic                done, done_next;
    logic [DATA_WID-1:0] addend, sum;
    logic                carry;
    logic [31:0]         opa_wr, opb_wr, rd_data;
    logic                req, wr, ctrl_wr, start_go, clr_cmd, last_step;

    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr        = req & wb_we_i;
    assign ctrl_wr   = wr & (wb_adr_i == ADR_CTRL) & wb_sel_i[0];
    assign start_go  = ctrl_wr & wb_dat_i[CTRL_START] & (state == ST_IDLE);
    assign clr_cmd   = ctrl_wr & wb_dat_i[CTRL_DONE_CLR];
    assign last_step = (state == ST_RUN) && (cnt == CNT_WID'(DATA_WID - 1));

    assign opa_wr = byte_merge(32'(opa), wb_dat_i, wb_sel_i);
    assign opb_wr = byte_merge(32'(opb), wb_dat_i, wb_sel_i);

    assign addend = mplier[0] ? mcand : '0;

    cpu_wb_cla_adder #(.DATA_WID(DATA_WID)) u_adder (
        .a         (acc),
        .b         (addend),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry)
    );

    // Completion outranks a simultaneous DONE_CLR; START can never coincide with it.
    always_comb begin
        done_next = done;
        if (start_go)       done_next = 1'b0;
        else if (last_step) done_next = 1'b1;
        else if (clr_cmd)   done_next = 1'b0;
    end

`ifdef CPU_WB_MUL_IRQ_EN
    logic irq_ena, irq_ena_next;
    assign irq_ena_next = ctrl_wr ? wb_dat_i[CTRL_IRQ_ENA] : irq_ena;
`endif

    // NOTE: every path assigns rd_data a default first, so no latch can be inferred.
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ADR_OPA:    rd_data = 32'(opa);
            ADR_OPB:    rd_data = 32'(opb);
            ADR_CTRL: begin
                rd_data[CTRL_BUSY] = (state == ST_RUN);
                rd_data[CTRL_DONE] = done;
`ifdef CPU_WB_MUL_IRQ_EN
                rd_data[CTRL_IRQ_ENA] = irq_ena;
`endif
            end
            ADR_RES_LO: rd_data = 32'(res_lo);
            ADR_RES_HI: rd_data = 32'(res_hi);
            default:    rd_data = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            opa      <= '0;
            opb      <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req & ~wb_we_i) ? rd_data : '0;
            if (wr && wb_adr_i == ADR_OPA) opa <= opa_wr[DATA_WID-1:0];
            if (wr && wb_adr_i == ADR_OPB) opb <= opb_wr[DATA_WID-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            done   <= 1'b0;
        end else begin
            done <= done_next;
            if (start_go) begin
                state  <= ST_RUN;
                mcand  <= opa;
                mplier <= opb;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == ST_RUN) begin
                // {carry, sum, mplier} >> 1: carry lands in the accumulator MSB.
                acc    <= {carry, sum[DATA_WID-1:1]};
                mplier <= {sum[0], mplier[DATA_WID-1:1]};
                cnt    <= cnt + 1'b1;
                if (last_step) begin
                    state  <= ST_IDLE;
                    res_hi <= {carry, sum[DATA_WID-1:1]};
                    res_lo <= {sum[0], mplier[DATA_WID-1:1]};
                end
            end
        end
    end

`ifdef CPU_WB_MUL_IRQ_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_ena <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            irq_ena <= irq_ena_next;
            irq_o   <= done_next & irq_ena_next;
        end
    end
`endif

endmodule
